// File: rtl/dca_product_accumulator_pkg.sv
// Shared definitions for the product accumulator: the tensor scalar width,
// the FSM state encoding and the signed saturation bounds at scalar width.
package dca_product_accumulator_pkg;

    // Tensor scalar width shared with the multiplier datapath.
    localparam int unsigned TENSOR_BW_SCALAR = 32;
    localparam int unsigned DEFAULT_BW_LENGTH = 16;
    localparam int unsigned DEFAULT_BW_GUARD  = 8;

    // Accumulator FSM: IDLE waits for a first beat, ACCUM collects the rest.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

    // Signed saturation bounds at the scalar width.
    localparam logic [TENSOR_BW_SCALAR-1:0] SCALAR_MAX = {1'b0, {(TENSOR_BW_SCALAR-1){1'b1}}};
    localparam logic [TENSOR_BW_SCALAR-1:0] SCALAR_MIN = {1'b1, {(TENSOR_BW_SCALAR-1){1'b0}}};

endpackage

// File: rtl/dca_signed_saturator.sv
// Clips a signed W_IN-bit value into the signed W_OUT-bit range.
// Ports: din_i (signed input), dout_c (clipped value), clip_c (1 when clipped).
module dca_signed_saturator #(
    parameter int unsigned W_IN  = 40,
    parameter int unsigned W_OUT = 32
) (
    input  logic [W_IN-1:0]  din_i,
    output logic [W_OUT-1:0] dout_c,
    output logic             clip_c
);

    localparam int unsigned W_TOP = W_IN - W_OUT + 1;

    // The value fits iff every bit from the output sign bit upward matches.
    logic [W_TOP-1:0] top_bits;
    logic             fits;

    assign top_bits = din_i[W_IN-1:W_OUT-1];
    assign fits     = (top_bits == '0) || (top_bits == '1);

    always_comb begin
        dout_c = din_i[W_OUT-1:0];
        clip_c = 1'b0;
        if (!fits) begin
            clip_c = 1'b1;
            dout_c = din_i[W_IN-1] ? {1'b1, {(W_OUT-1){1'b0}}}
                                   : {1'b0, {(W_OUT-1){1'b1}}};
        end
    end

endmodule

// File: rtl/dca_product_accumulator.sv
// Accumulates a stream of signed products into dot-product results of a
// configurable beat count, saturating each result to the scalar width and
// holding it in a single output register with valid/ready handshake.
// Ports: clk, rstnn (async active-low), enable (global advance), clear
// (synchronous flush), cfg_length (beats per product, 0 => 1), in_valid /
// in_value (product stream, no backpressure), out_valid / out_ready /
// out_result / out_saturated (result handshake), busy (in ACCUM),
// overrun (sticky result-dropped flag).
module dca_product_accumulator
    import dca_product_accumulator_pkg::*;
#(
    parameter int unsigned BW_SCALAR = TENSOR_BW_SCALAR,
    parameter int unsigned BW_LENGTH = DEFAULT_BW_LENGTH,
    parameter int unsigned BW_GUARD  = DEFAULT_BW_GUARD
) (
    input  logic                 clk,
    input  logic                 rstnn,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [BW_LENGTH-1:0] cfg_length,
    input  logic                 in_valid,
    input  logic [BW_SCALAR-1:0] in_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BW_SCALAR-1:0] out_result,
    output logic                 out_saturated,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned BW_ACC = BW_SCALAR + BW_GUARD;

    acc_state_e           state_q, state_d;
    logic [BW_ACC-1:0]    acc_q, acc_d;
    logic [BW_LENGTH-1:0] cnt_q, cnt_d;
    logic [BW_LENGTH-1:0] len_q, len_d;
    logic                 out_valid_q, out_valid_d;
    logic [BW_SCALAR-1:0] out_result_q, out_result_d;
    logic                 out_sat_q, out_sat_d;
    logic                 overrun_q, overrun_d;

    logic [BW_LENGTH-1:0] len_eff_c;
    logic [BW_ACC-1:0]    in_ext_c;
    logic [BW_ACC-1:0]    sum_c;
    logic [BW_SCALAR-1:0] sat_value_c;
    logic                 sat_clip_c;
    logic                 final_beat_c;

    assign len_eff_c = (cfg_length == '0) ? BW_LENGTH'(1) : cfg_length;
    assign in_ext_c  = BW_ACC'($signed(in_value));
    // A first beat starts from zero, so a length-1 product is in_value alone.
    assign sum_c     = ((state_q == ST_ACCUM) ? acc_q : '0) + in_ext_c;

    dca_signed_saturator #(
        .W_IN  (BW_ACC),
        .W_OUT (BW_SCALAR)
    ) u_sat (
        .din_i  (sum_c),
        .dout_c (sat_value_c),
        .clip_c (sat_clip_c)
    );

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_sat_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_sat_q    <= out_sat_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_sat_d    = out_sat_q;
        overrun_d    = overrun_q;
        final_beat_c = 1'b0;

        if (enable) begin
            if (clear) begin
                state_d     = ST_IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                out_valid_d = 1'b0;
                overrun_d   = 1'b0;
            end else begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (in_valid) begin
                    unique case (state_q)
                        ST_IDLE: begin
                            len_d = len_eff_c;
                            if (len_eff_c == BW_LENGTH'(1)) begin
                                final_beat_c = 1'b1;
                            end else begin
                                acc_d   = in_ext_c;
                                cnt_d   = BW_LENGTH'(1);
                                state_d = ST_ACCUM;
                            end
                        end
                        ST_ACCUM: begin
                            if (cnt_q + BW_LENGTH'(1) == len_q) begin
                                final_beat_c = 1'b1;
                                state_d      = ST_IDLE;
                                cnt_d        = '0;
                                acc_d        = '0;
                            end else begin
                                acc_d = sum_c;
                                cnt_d = cnt_q + BW_LENGTH'(1);
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                    // Output register is free if empty or drained this cycle.
                    if (final_beat_c) begin
                        if (!out_valid_q || out_ready) begin
                            out_valid_d  = 1'b1;
                            out_result_d = sat_value_c;
                            out_sat_d    = sat_clip_c;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_saturated = out_sat_q;
    assign busy          = (state_q == ST_ACCUM);
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_dca_product_accumulator.sv
// Bench for dca_product_accumulator: directed table, async-reset sequence and
// randomized traffic checked against a behavioural dot-product model.
module tb_dca_product_accumulator;

    logic        clk;
    logic        rstnn;
    logic        enable;
    logic        clear;
    logic [15:0] cfg_length;
    logic        in_valid;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_saturated;
    logic        busy;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    dca_product_accumulator dut (
        .clk           (clk),
        .rstnn         (rstnn),
        .enable        (enable),
        .clear         (clear),
        .cfg_length    (cfg_length),
        .in_valid      (in_valid),
        .in_value      (in_value),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_saturated (out_saturated),
        .busy          (busy),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          en;
        bit          clr;
        logic [15:0] len;
        bit          v;
        logic [31:0] val;
        bit          rdy;
        bit          ev;
        logic [31:0] er;
        bit          es;
        bit          eb;
        bit          eo;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit en, bit clr, logic [15:0] len, bit v, logic [31:0] val,
                                bit rdy, bit ev, logic [31:0] er, bit es, bit eb, bit eo);
        vec_t r;
        r.en = en; r.clr = clr; r.len = len; r.v = v; r.val = val; r.rdy = rdy;
        r.ev = ev; r.er = er; r.es = es; r.eb = eb; r.eo = eo;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit en, input bit clr, input logic [15:0] len, input bit v,
                         input logic [31:0] val, input bit rdy);
        enable     = en;
        clear      = clr;
        cfg_length = len;
        in_valid   = v;
        in_value   = val;
        out_ready  = rdy;
    endtask

    // Behavioural model: a product is a list of beats summed in a 40-bit
    // wrapping accumulator, then clipped to the signed 32-bit range.
    bit     m_valid, m_sat, m_ovr, m_inprod;
    longint m_result, m_sum;
    int     m_beats, m_len;

    function automatic longint wrap40(input longint x);
        return (x <<< 24) >>> 24;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_sat = 0; m_ovr = 0; m_inprod = 0;
        m_result = 0; m_sum = 0; m_beats = 0; m_len = 1;
    endtask

    task automatic model_step(input bit en, input bit clr, input logic [15:0] len, input bit v,
                              input logic [31:0] val, input bit rdy);
        bit     had_valid;
        longint s;
        if (!en) return;
        if (clr) begin
            m_inprod = 0; m_beats = 0; m_sum = 0; m_valid = 0; m_ovr = 0;
            return;
        end
        had_valid = m_valid;
        if (m_valid && rdy) m_valid = 0;
        if (v) begin
            if (!m_inprod) begin
                m_len = (len == 0) ? 1 : int'(len);
                m_sum = 0;
                m_beats = 0;
            end
            m_sum = wrap40(m_sum + longint'($signed(val)));
            m_beats++;
            if (m_beats == m_len) begin
                m_inprod = 0;
                s = m_sum;
                if (!had_valid || rdy) begin
                    m_valid = 1;
                    if (s > 64'sd2147483647) begin
                        m_result = 64'sd2147483647; m_sat = 1;
                    end else if (s < -64'sd2147483648) begin
                        m_result = -64'sd2147483648; m_sat = 1;
                    end else begin
                        m_result = s; m_sat = 0;
                    end
                end else begin
                    m_ovr = 1;
                end
            end else begin
                m_inprod = 1;
            end
        end
    endtask

    task automatic rstep(input bit en, input bit clr, input logic [15:0] len, input bit v,
                         input logic [31:0] val, input bit rdy);
        logic [31:0] exp_r;
        drive(en, clr, len, v, val, rdy);
        model_step(en, clr, len, v, val, rdy);
        @(negedge clk);
        chk("rand_valid", 32'(out_valid), 32'(m_valid));
        chk("rand_busy", 32'(busy), 32'(m_inprod));
        chk("rand_overrun", 32'(overrun), 32'(m_ovr));
        if (m_valid) begin
            exp_r = m_result[31:0];
            chk("rand_result", out_result, exp_r);
            chk("rand_sat", 32'(out_saturated), 32'(m_sat));
        end
    endtask

    initial begin
        logic [31:0] rv;
        rstnn = 1'b0;
        drive(0, 0, 16'd1, 0, 32'd0, 0);
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_result", out_result, 32'd0);
        chk("reset_sat", 32'(out_saturated), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        rstnn = 1'b1;
        @(negedge clk);

        // Length 4: 3,-1,10,2 -> 14, busy for three cycles.
        add(1,0,16'd4,1,32'd3,1,          0,32'd0,0,1,0);
        add(1,0,16'd4,1,32'hFFFFFFFF,1,   0,32'd0,0,1,0);
        add(1,0,16'd4,1,32'd10,1,         0,32'd0,0,1,0);
        add(1,0,16'd4,1,32'd2,1,          1,32'd14,0,0,0);
        add(1,0,16'd4,0,32'd0,1,          0,32'd0,0,0,0);
        // Positive and negative saturation.
        add(1,0,16'd2,1,32'h7FFFFFFF,1,   0,32'd0,0,1,0);
        add(1,0,16'd2,1,32'h7FFFFFFF,1,   1,32'h7FFFFFFF,1,0,0);
        add(1,0,16'd2,1,32'h80000000,1,   0,32'd0,0,1,0);
        add(1,0,16'd2,1,32'h80000000,1,   1,32'h80000000,1,0,0);
        add(1,0,16'd2,0,32'd0,1,          0,32'd0,0,0,0);
        // Length 1 with consumer stalled: second result dropped.
        add(1,0,16'd1,1,32'd5,0,          1,32'd5,0,0,0);
        add(1,0,16'd1,1,32'd7,0,          1,32'd5,0,0,1);
        add(1,0,16'd1,0,32'd0,1,          0,32'd0,0,0,1);
        // Enable low freezes everything, including in_valid.
        add(1,0,16'd3,1,32'd1,1,          0,32'd0,0,1,1);
        add(1,0,16'd3,1,32'd2,1,          0,32'd0,0,1,1);
        for (int i = 0; i < 4; i++) add(0,0,16'd3,1,32'd99,1, 0,32'd0,0,1,1);
        add(1,0,16'd3,1,32'd4,1,          1,32'd7,0,0,1);
        add(1,0,16'd3,0,32'd0,1,          0,32'd0,0,0,1);
        // Clear mid-product, then a fresh product.
        add(1,0,16'd3,1,32'd1,1,          0,32'd0,0,1,1);
        add(1,0,16'd3,1,32'd2,1,          0,32'd0,0,1,1);
        add(1,1,16'd3,1,32'd9,1,          0,32'd0,0,0,0);
        add(1,0,16'd3,1,32'd5,0,          0,32'd0,0,1,0);
        add(1,0,16'd3,1,32'd5,0,          0,32'd0,0,1,0);
        add(1,0,16'd3,1,32'd5,0,          1,32'd15,0,0,0);
        // Length 0 acts as 1; accept and reload in the same cycle.
        add(1,0,16'd0,1,32'd9,1,          1,32'd9,0,0,0);
        add(1,0,16'd0,1,32'hFFFFFFFD,1,   1,32'hFFFFFFFD,0,0,0);
        add(1,0,16'd0,0,32'd0,1,          0,32'd0,0,0,0);
        // Length latched on the first beat.
        add(1,0,16'd2,1,32'd10,1,         0,32'd0,0,1,0);
        add(1,0,16'd5,1,32'd20,1,         1,32'd30,0,0,0);
        add(0,0,16'd5,0,32'd0,1,          1,32'd30,0,0,0);
        add(1,0,16'd5,0,32'd0,1,          0,32'd0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].clr, tbl[i].len, tbl[i].v, tbl[i].val, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'(tbl[i].eo));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_result", i), out_result, tbl[i].er);
                chk($sformatf("tbl%0d_sat", i), 32'(out_saturated), 32'(tbl[i].es));
            end
        end

        // Asynchronous reset between edges, mid-product with a result held.
        drive(1, 0, 16'd1, 1, 32'd11, 0);
        @(negedge clk);
        drive(1, 0, 16'd3, 1, 32'd1, 0);
        @(negedge clk);
        drive(1, 0, 16'd3, 1, 32'd2, 0);
        @(negedge clk);
        chk("arst_pre_busy", 32'(busy), 32'd1);
        chk("arst_pre_valid", 32'(out_valid), 32'd1);
        #2 rstnn = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_result", out_result, 32'd0);
        chk("arst_sat", 32'(out_saturated), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        #1 rstnn = 1'b1;
        drive(1, 0, 16'd3, 1, 32'd5, 1);
        @(negedge clk);
        drive(1, 0, 16'd3, 1, 32'd6, 1);
        @(negedge clk);
        drive(1, 0, 16'd3, 1, 32'd7, 1);
        @(negedge clk);
        chk("arst_next_valid", 32'(out_valid), 32'd1);
        chk("arst_next_result", out_result, 32'd18);
        chk("arst_next_busy", 32'(busy), 32'd0);

        // Randomized traffic against the model from a clean reset.
        rstnn = 1'b0;
        drive(0, 0, 16'd1, 0, 32'd0, 0);
        model_reset();
        @(negedge clk);
        rstnn = 1'b1;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       rv = ($urandom_range(0, 1) == 1) ? 32'h7FFFFFF0 + 32'($urandom_range(0, 15))
                                                          : 32'h80000000 + 32'($urandom_range(0, 15));
                1:       rv = $urandom();
                default: rv = 32'($signed(32'($urandom_range(0, 200)) - 32'd100));
            endcase
            rstep(($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 39) == 0),
                  16'($urandom_range(0, 4)),
                  ($urandom_range(0, 9) < 7),
                  rv,
                  ($urandom_range(0, 9) < 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
